// File: rtl/gps_scenario_sequencer.sv
// gps_scenario_sequencer
// Run control, sample timebase and atomic shadow->active parameter commit for
// the per-satellite GPS emulator datapath.
// Optional feature macro: GPS_SEQ_DOP_RATE_EN adds a per-satellite signed
// Doppler-rate shadow and steps dop_freq by it every RATE_DIV samples.
module gps_scenario_sequencer #(
  parameter int          Nsat          = 4,
  parameter int          RATE_DIV      = 16368,
  parameter logic [31:0] CODE_FREQ_DEF = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dv_in,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  cfg_we,
  input  logic [5:0]            cfg_sat,
  input  logic [2:0]            cfg_field,
  input  logic [31:0]           cfg_data,
  input  logic                  commit_req,
  input  logic [31:0]           commit_time,
  output logic                  emu_reset,
  output logic [31:0]           sample_count,
  output logic                  commit_busy,
  output logic                  commit_ack,
  output logic                  late_err,
  output logic                  busy_err,
  output logic [Nsat-1:0][31:0] code_freq,
  output logic [Nsat-1:0][31:0] dop_freq,
  output logic [Nsat-1:0][15:0] gain,
  output logic [Nsat-1:0][5:0]  ca_sel
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        emu_reset_q, emu_reset_d;
  logic [31:0] count_q, count_d;
  logic [31:0] commit_time_q, commit_time_d;
  logic        late_pend_q, late_pend_d;
  logic        busy_q, busy_d;
  logic        ack_q, ack_d;
  logic        late_q, late_d;
  logic        berr_q, berr_d;
  logic        apply_s;

  logic [Nsat-1:0][31:0] code_q, code_d, code_sh_q, code_sh_d;
  logic [Nsat-1:0][31:0] dop_q, dop_d, dop_sh_q, dop_sh_d;
  logic [Nsat-1:0][15:0] gain_q, gain_d, gain_sh_q, gain_sh_d;
  logic [Nsat-1:0][5:0]  ca_q, ca_d, ca_sh_q, ca_sh_d;

`ifdef GPS_SEQ_DOP_RATE_EN
  localparam logic [31:0] RATE_LAST = 32'(RATE_DIV - 1);
  logic [Nsat-1:0][31:0] rate_q, rate_d, rate_sh_q, rate_sh_d;
  logic [31:0]           rate_cnt_q, rate_cnt_d;
  logic                  rate_step_s;
`endif

  // Run-control FSM, sample timebase and commit scheduling.
  always_comb begin
    state_d       = state_q;
    emu_reset_d   = emu_reset_q;
    count_d       = count_q;
    commit_time_d = commit_time_q;
    late_pend_d   = late_pend_q;
    late_d        = 1'b0;
    berr_d        = 1'b0;
    apply_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        count_d = 32'd0;
        // Commits while idle need no timing: transfer straight away.
        apply_s = commit_req;
        if (start && !stop) begin
          state_d     = ST_RUN;
          emu_reset_d = 1'b0;
        end else begin
          emu_reset_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (dv_in) count_d = count_q + 32'd1;
        else       count_d = count_q;
        if (stop) begin
          state_d     = ST_IDLE;
          emu_reset_d = 1'b1;
          count_d     = 32'd0;
        end else if (commit_req) begin
          state_d       = ST_ARMED;
          commit_time_d = commit_time;
          // A target more than half the counter range ahead is really behind us.
          if ((commit_time - count_q) >= 32'h8000_0000) begin
            late_d      = 1'b1;
            late_pend_d = 1'b1;
          end else begin
            late_pend_d = 1'b0;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_ARMED: begin
        if (dv_in) count_d = count_q + 32'd1;
        else       count_d = count_q;
        // Any request while armed (including the apply cycle) is dropped.
        berr_d = commit_req;
        if (stop) begin
          state_d     = ST_IDLE;
          emu_reset_d = 1'b1;
          count_d     = 32'd0;
          late_pend_d = 1'b0;
        end else if (late_pend_q || (dv_in && (count_q == commit_time_q))) begin
          state_d     = ST_RUN;
          apply_s     = 1'b1;
          late_pend_d = 1'b0;
        end else begin
          state_d = ST_ARMED;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        emu_reset_d = 1'b1;
        count_d     = 32'd0;
        late_pend_d = 1'b0;
      end
    endcase
    ack_d  = apply_s;
    busy_d = (state_d == ST_ARMED);
  end

`ifdef GPS_SEQ_DOP_RATE_EN
  // Doppler-rate sample divider; restarts on every start.
  always_comb begin
    rate_cnt_d  = rate_cnt_q;
    rate_step_s = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start && !stop) rate_cnt_d = 32'd0;
      else                rate_cnt_d = rate_cnt_q;
    end else if (dv_in) begin
      if (rate_cnt_q == RATE_LAST) begin
        rate_cnt_d  = 32'd0;
        rate_step_s = 1'b1;
      end else begin
        rate_cnt_d = rate_cnt_q + 32'd1;
      end
    end else begin
      rate_cnt_d = rate_cnt_q;
    end
  end
`endif

  // Shadow writes and the all-at-once shadow->active transfer.
  always_comb begin
    code_sh_d = code_sh_q;
    dop_sh_d  = dop_sh_q;
    gain_sh_d = gain_sh_q;
    ca_sh_d   = ca_sh_q;
    code_d    = code_q;
    dop_d     = dop_q;
    gain_d    = gain_q;
    ca_d      = ca_q;
`ifdef GPS_SEQ_DOP_RATE_EN
    rate_sh_d = rate_sh_q;
    rate_d    = rate_q;
`endif
    // Actives take the pre-write shadow; an apply overrides a rate step.
    if (apply_s) begin
      code_d = code_sh_q;
      dop_d  = dop_sh_q;
      gain_d = gain_sh_q;
      ca_d   = ca_sh_q;
`ifdef GPS_SEQ_DOP_RATE_EN
      rate_d = rate_sh_q;
`endif
    end else begin
`ifdef GPS_SEQ_DOP_RATE_EN
      if (rate_step_s) begin
        for (int i = 0; i < Nsat; i++) dop_d[i] = dop_q[i] + rate_q[i];
      end else begin
        dop_d = dop_q;
      end
`else
      dop_d = dop_q;
`endif
    end
    for (int i = 0; i < Nsat; i++) begin
      if (cfg_we && ({26'd0, cfg_sat} == $unsigned(i))) begin
        case (cfg_field)
          3'd0:    code_sh_d[i] = cfg_data;
          3'd1:    dop_sh_d[i]  = cfg_data;
          3'd2:    gain_sh_d[i] = cfg_data[15:0];
          3'd3:    ca_sh_d[i]   = cfg_data[5:0];
`ifdef GPS_SEQ_DOP_RATE_EN
          3'd4:    rate_sh_d[i] = cfg_data;
`endif
          default: code_sh_d[i] = code_sh_q[i];
        endcase
      end else begin
        code_sh_d[i] = code_sh_q[i];
      end
    end
  end

  // State and parameter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      emu_reset_q   <= 1'b1;
      count_q       <= 32'd0;
      commit_time_q <= 32'd0;
      late_pend_q   <= 1'b0;
      busy_q        <= 1'b0;
      ack_q         <= 1'b0;
      late_q        <= 1'b0;
      berr_q        <= 1'b0;
      for (int i = 0; i < Nsat; i++) begin
        code_q[i]    <= CODE_FREQ_DEF;
        code_sh_q[i] <= CODE_FREQ_DEF;
        dop_q[i]     <= 32'd0;
        dop_sh_q[i]  <= 32'd0;
        gain_q[i]    <= 16'd0;
        gain_sh_q[i] <= 16'd0;
        ca_q[i]      <= 6'(i);
        ca_sh_q[i]   <= 6'(i);
`ifdef GPS_SEQ_DOP_RATE_EN
        rate_q[i]    <= 32'd0;
        rate_sh_q[i] <= 32'd0;
`endif
      end
`ifdef GPS_SEQ_DOP_RATE_EN
      rate_cnt_q <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      emu_reset_q   <= emu_reset_d;
      count_q       <= count_d;
      commit_time_q <= commit_time_d;
      late_pend_q   <= late_pend_d;
      busy_q        <= busy_d;
      ack_q         <= ack_d;
      late_q        <= late_d;
      berr_q        <= berr_d;
      code_q        <= code_d;
      code_sh_q     <= code_sh_d;
      dop_q         <= dop_d;
      dop_sh_q      <= dop_sh_d;
      gain_q        <= gain_d;
      gain_sh_q     <= gain_sh_d;
      ca_q          <= ca_d;
      ca_sh_q       <= ca_sh_d;
`ifdef GPS_SEQ_DOP_RATE_EN
      rate_q        <= rate_d;
      rate_sh_q     <= rate_sh_d;
      rate_cnt_q    <= rate_cnt_d;
`endif
    end
  end

  assign emu_reset    = emu_reset_q;
  assign sample_count = count_q;
  assign commit_busy  = busy_q;
  assign commit_ack   = ack_q;
  assign late_err     = late_q;
  assign busy_err     = berr_q;
  assign code_freq    = code_q;
  assign dop_freq     = dop_q;
  assign gain         = gain_q;
  assign ca_sel       = ca_q;

endmodule

// File: tb/tb_gps_scenario_sequencer.sv
// Testbench for gps_scenario_sequencer: constant-vector table, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_gps_scenario_sequencer;

  localparam int NSAT = 4;
  localparam int RDIV = 8;
`ifdef GPS_SEQ_DOP_RATE_EN
  localparam bit RATE_ON = 1'b1;
`else
  localparam bit RATE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, dv_in, start, stop, cfg_we, commit_req;
  logic [5:0]  cfg_sat;
  logic [2:0]  cfg_field;
  logic [31:0] cfg_data, commit_time;
  logic        emu_reset, commit_busy, commit_ack, late_err, busy_err;
  logic [31:0] sample_count;
  logic [NSAT-1:0][31:0] code_freq, dop_freq;
  logic [NSAT-1:0][15:0] gain;
  logic [NSAT-1:0][5:0]  ca_sel;

  int checks = 0;
  int errors = 0;

  gps_scenario_sequencer #(.Nsat(NSAT), .RATE_DIV(RDIV), .CODE_FREQ_DEF(32'h0)) dut (
    .clk(clk), .reset(reset), .dv_in(dv_in), .start(start), .stop(stop),
    .cfg_we(cfg_we), .cfg_sat(cfg_sat), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .commit_req(commit_req), .commit_time(commit_time), .emu_reset(emu_reset),
    .sample_count(sample_count), .commit_busy(commit_busy), .commit_ack(commit_ack),
    .late_err(late_err), .busy_err(busy_err), .code_freq(code_freq), .dop_freq(dop_freq),
    .gain(gain), .ca_sel(ca_sel)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  bit          m_run, m_armed, m_late;
  logic [31:0] m_cnt, m_time, m_rcnt;
  logic [31:0] m_code[NSAT], m_dop[NSAT], m_rate[NSAT];
  logic [31:0] s_code[NSAT], s_dop[NSAT], s_rate[NSAT];
  logic [15:0] m_gain[NSAT], s_gain[NSAT];
  logic [5:0]  m_ca[NSAT], s_ca[NSAT];
  logic        e_ack, e_late, e_berr;

  task automatic model_edge();
    bit apply, rstep;
    apply = 1'b0; rstep = 1'b0;
    e_ack = 1'b0; e_late = 1'b0; e_berr = 1'b0;
    if (reset) begin
      m_run = 1'b0; m_armed = 1'b0; m_late = 1'b0;
      m_cnt = 32'd0; m_time = 32'd0; m_rcnt = 32'd0;
      for (int i = 0; i < NSAT; i++) begin
        m_code[i] = 32'd0; s_code[i] = 32'd0; m_dop[i] = 32'd0; s_dop[i] = 32'd0;
        m_rate[i] = 32'd0; s_rate[i] = 32'd0; m_gain[i] = 16'd0; s_gain[i] = 16'd0;
        m_ca[i] = 6'(i); s_ca[i] = 6'(i);
      end
    end else begin
      if (m_run && dv_in) begin
        if (m_rcnt == 32'(RDIV - 1)) begin rstep = 1'b1; m_rcnt = 32'd0; end
        else m_rcnt = m_rcnt + 32'd1;
      end
      if (!m_run) begin
        if (commit_req) apply = 1'b1;
        if (start && !stop) begin m_run = 1'b1; m_rcnt = 32'd0; end
      end else begin
        if (m_armed && commit_req) e_berr = 1'b1;
        if (stop) begin
          m_run = 1'b0; m_armed = 1'b0; m_cnt = 32'd0;
        end else begin
          if (m_armed && (m_late || (dv_in && m_cnt == m_time))) begin
            apply = 1'b1; m_armed = 1'b0;
          end else if (!m_armed && commit_req) begin
            m_armed = 1'b1; m_time = commit_time;
            m_late = ((commit_time - m_cnt) >= 32'h8000_0000);
            e_late = m_late;
          end
          if (dv_in) m_cnt = m_cnt + 32'd1;
        end
      end
      e_ack = apply;
      for (int i = 0; i < NSAT; i++) begin
        if (apply) begin
          m_code[i] = s_code[i]; m_dop[i] = s_dop[i]; m_gain[i] = s_gain[i];
          m_ca[i] = s_ca[i]; m_rate[i] = s_rate[i];
        end else if (RATE_ON && rstep) begin
          m_dop[i] = m_dop[i] + m_rate[i];
        end
      end
      if (cfg_we && cfg_sat < 6'(NSAT)) begin
        case (cfg_field)
          3'd0: s_code[cfg_sat] = cfg_data;
          3'd1: s_dop[cfg_sat]  = cfg_data;
          3'd2: s_gain[cfg_sat] = cfg_data[15:0];
          3'd3: s_ca[cfg_sat]   = cfg_data[5:0];
          3'd4: if (RATE_ON) s_rate[cfg_sat] = cfg_data;
          default: ;
        endcase
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("emu_reset", 32'(emu_reset), {31'd0, !m_run});
    chk("sample_count", sample_count, m_cnt);
    chk("commit_busy", 32'(commit_busy), {31'd0, m_armed});
    chk("commit_ack", 32'(commit_ack), 32'(e_ack));
    chk("late_err", 32'(late_err), 32'(e_late));
    chk("busy_err", 32'(busy_err), 32'(e_berr));
    for (int i = 0; i < NSAT; i++) begin
      chk("code_freq", code_freq[i], m_code[i]);
      chk("dop_freq", dop_freq[i], m_dop[i]);
      chk("gain", 32'(gain[i]), 32'(m_gain[i]));
      chk("ca_sel", 32'(ca_sel[i]), 32'(m_ca[i]));
    end
  endtask

  // One clock: model follows the inputs present at the edge, compare after.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic clr();
    start = 1'b0; stop = 1'b0; dv_in = 1'b0; cfg_we = 1'b0; cfg_sat = 6'd0;
    cfg_field = 3'd0; cfg_data = 32'd0; commit_req = 1'b0; commit_time = 32'd0;
  endtask

  task automatic do_reset();
    clr(); reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  task automatic wr(input logic [5:0] sat, input logic [2:0] fld, input logic [31:0] d);
    cfg_we = 1'b1; cfg_sat = sat; cfg_field = fld; cfg_data = d; step(); cfg_we = 1'b0;
  endtask

  typedef struct {
    logic start, stop, dv, we; logic [5:0] sat; logic [2:0] field; logic [31:0] data;
    logic creq; logic [31:0] ctime;
    logic e_emu; logic [31:0] e_cnt; logic e_busy, e_ack, e_late, e_berr; logic [31:0] e_dop2;
  } vec_t;

  vec_t vt[14];
  logic [23:0] exp_ca;
  int  n;
  bit  done;

  initial begin
    // start stop dv we sat field data creq ctime | emu cnt busy ack late berr dop2
    vt[0]  = '{1'b0,1'b0,1'b1,1'b0,6'd0,3'd0,32'd0,1'b0,32'd0,   1'b1,32'd0,1'b0,1'b0,1'b0,1'b0,32'd0};
    vt[1]  = '{1'b1,1'b0,1'b1,1'b0,6'd0,3'd0,32'd0,1'b0,32'd0,   1'b0,32'd0,1'b0,1'b0,1'b0,1'b0,32'd0};
    vt[2]  = '{1'b0,1'b0,1'b1,1'b0,6'd0,3'd0,32'd0,1'b0,32'd0,   1'b0,32'd1,1'b0,1'b0,1'b0,1'b0,32'd0};
    vt[3]  = '{1'b0,1'b0,1'b0,1'b0,6'd0,3'd0,32'd0,1'b0,32'd0,   1'b0,32'd1,1'b0,1'b0,1'b0,1'b0,32'd0};
    vt[4]  = '{1'b0,1'b0,1'b1,1'b1,6'd2,3'd1,32'h1000,1'b0,32'd0,1'b0,32'd2,1'b0,1'b0,1'b0,1'b0,32'd0};
    vt[5]  = '{1'b0,1'b0,1'b1,1'b0,6'd0,3'd0,32'd0,1'b1,32'd4,   1'b0,32'd3,1'b1,1'b0,1'b0,1'b0,32'd0};
    vt[6]  = '{1'b0,1'b0,1'b0,1'b0,6'd0,3'd0,32'd0,1'b0,32'd0,   1'b0,32'd3,1'b1,1'b0,1'b0,1'b0,32'd0};
    vt[7]  = '{1'b0,1'b0,1'b1,1'b0,6'd0,3'd0,32'd0,1'b0,32'd0,   1'b0,32'd4,1'b1,1'b0,1'b0,1'b0,32'd0};
    vt[8]  = '{1'b0,1'b0,1'b1,1'b0,6'd0,3'd0,32'd0,1'b0,32'd0,   1'b0,32'd5,1'b0,1'b1,1'b0,1'b0,32'h1000};
    vt[9]  = '{1'b0,1'b0,1'b0,1'b0,6'd0,3'd0,32'd0,1'b0,32'd0,   1'b0,32'd5,1'b0,1'b0,1'b0,1'b0,32'h1000};
    vt[10] = '{1'b0,1'b0,1'b0,1'b0,6'd0,3'd0,32'd0,1'b1,32'd2,   1'b0,32'd5,1'b1,1'b0,1'b1,1'b0,32'h1000};
    vt[11] = '{1'b0,1'b0,1'b0,1'b0,6'd0,3'd0,32'd0,1'b1,32'd100, 1'b0,32'd5,1'b0,1'b1,1'b0,1'b1,32'h1000};
    vt[12] = '{1'b0,1'b1,1'b0,1'b0,6'd0,3'd0,32'd0,1'b0,32'd0,   1'b1,32'd0,1'b0,1'b0,1'b0,1'b0,32'h1000};
    vt[13] = '{1'b0,1'b0,1'b1,1'b0,6'd0,3'd0,32'd0,1'b0,32'd0,   1'b1,32'd0,1'b0,1'b0,1'b0,1'b0,32'h1000};

    // Reset state.
    do_reset();
    exp_ca = {6'd3, 6'd2, 6'd1, 6'd0};
    chk("reset emu_reset", 32'(emu_reset), 32'd1);
    chk("reset sample_count", sample_count, 32'd0);
    chk("reset ca_sel", 32'(ca_sel), 32'(exp_ca));

    // Constant vector table.
    for (int k = 0; k < 14; k++) begin
      start = vt[k].start; stop = vt[k].stop; dv_in = vt[k].dv; cfg_we = vt[k].we;
      cfg_sat = vt[k].sat; cfg_field = vt[k].field; cfg_data = vt[k].data;
      commit_req = vt[k].creq; commit_time = vt[k].ctime;
      step();
      chk("vec emu_reset", 32'(emu_reset), 32'(vt[k].e_emu));
      chk("vec sample_count", sample_count, vt[k].e_cnt);
      chk("vec commit_busy", 32'(commit_busy), 32'(vt[k].e_busy));
      chk("vec commit_ack", 32'(commit_ack), 32'(vt[k].e_ack));
      chk("vec late_err", 32'(late_err), 32'(vt[k].e_late));
      chk("vec busy_err", 32'(busy_err), 32'(vt[k].e_berr));
      chk("vec dop_freq2", dop_freq[2], vt[k].e_dop2);
    end
    clr();

    // 100 samples after start; commit at 500 with dv_in every 4 clocks.
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    chk("start emu_reset", 32'(emu_reset), 32'd0);
    wr(6'd2, 3'd1, 32'h1000);
    commit_req = 1'b1; commit_time = 32'd500; step(); commit_req = 1'b0;
    n = 0; done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      dv_in = (c % 4 == 3);
      step();
      if (dv_in) begin
        n++;
        if (n == 100) chk("count after 100", sample_count, 32'd100);
        if (n == 500) begin
          chk("pre-apply dop2", dop_freq[2], 32'd0);
          chk("pre-apply ack", 32'(commit_ack), 32'd0);
        end
        if (n == 501) begin
          chk("apply dop2", dop_freq[2], 32'h1000);
          chk("apply ack", 32'(commit_ack), 32'd1);
          chk("apply busy", 32'(commit_busy), 32'd0);
          done = 1'b1;
        end
      end
    end
    chk("apply reached", 32'(done), 32'd1);
    dv_in = 1'b0; step();
    chk("ack single pulse", 32'(commit_ack), 32'd0);

    // Late commit at sample_count 1000, commit_time 900.
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    dv_in = 1'b1;
    for (int k = 0; k < 1000; k++) step();
    dv_in = 1'b0;
    chk("count 1000", sample_count, 32'd1000);
    wr(6'd0, 3'd0, 32'hABCD);
    commit_req = 1'b1; commit_time = 32'd900; step(); commit_req = 1'b0;
    chk("late_err pulse", 32'(late_err), 32'd1);
    chk("late not yet applied", code_freq[0], 32'd0);
    step();
    chk("late applied", code_freq[0], 32'hABCD);
    chk("late ack", 32'(commit_ack), 32'd1);

    // Second request while armed: busy_err, first commit_time kept.
    dv_in = 1'b1;
    wr(6'd1, 3'd2, 32'h0000_5A5A);
    commit_req = 1'b1; commit_time = sample_count + 32'd3; step();
    commit_time = sample_count + 32'd1; step(); commit_req = 1'b0;
    chk("busy_err pulse", 32'(busy_err), 32'd1);
    step();
    chk("no early apply", 32'(gain[1]), 32'd0);
    step();
    chk("original time apply", 32'(gain[1]), 32'h5A5A);
    chk("original time ack", 32'(commit_ack), 32'd1);
    dv_in = 1'b0;

    // Commit while idle; writes to absent satellites ignored.
    do_reset();
    wr(6'd3, 3'd3, 32'd17);
    wr(6'd5, 3'd0, 32'hDEAD);
    commit_req = 1'b1; step(); commit_req = 1'b0;
    chk("idle commit ca3", 32'(ca_sel[3]), 32'd17);
    chk("idle commit ack", 32'(commit_ack), 32'd1);

    // Doppler-rate stepping (or field 4 ignored without the feature).
    do_reset();
    wr(6'd0, 3'd4, 32'd5);
    commit_req = 1'b1; step(); commit_req = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    dv_in = 1'b1;
    for (int k = 0; k < 8; k++) step();
    chk("rate step 1", dop_freq[0], RATE_ON ? 32'd5 : 32'd0);
    for (int k = 0; k < 8; k++) step();
    chk("rate step 2", dop_freq[0], RATE_ON ? 32'd10 : 32'd0);

    // Stop while armed: emulator held in reset, no ack.
    commit_req = 1'b1; commit_time = sample_count + 32'd50; step(); commit_req = 1'b0;
    chk("armed busy", 32'(commit_busy), 32'd1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop emu_reset", 32'(emu_reset), 32'd1);
    chk("stop no ack", 32'(commit_ack), 32'd0);
    chk("stop busy clear", 32'(commit_busy), 32'd0);
    step();
    chk("stop no late ack", 32'(commit_ack), 32'd0);

    // Reset while armed discards the commit.
    start = 1'b1; step(); start = 1'b0;
    commit_req = 1'b1; commit_time = 32'd2; step(); commit_req = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    step();
    chk("reset no ack", 32'(commit_ack), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      reset      = ($urandom_range(0, 399) == 0);
      start      = ($urandom_range(0, 39) == 0);
      stop       = ($urandom_range(0, 119) == 0);
      dv_in      = ($urandom_range(0, 1) == 1);
      cfg_we     = ($urandom_range(0, 2) == 0);
      cfg_sat    = 6'($urandom_range(0, 7));
      cfg_field  = 3'($urandom_range(0, 7));
      if (RATE_ON && cfg_field == 3'd4) cfg_field = 3'd5;
      cfg_data   = $urandom;
      commit_req = ($urandom_range(0, 11) == 0);
      commit_time = m_cnt + 32'($urandom_range(0, 60)) - 32'd15;
      step();
    end
    reset = 1'b0; clr(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
